// File: rtl/kyber_pkg.sv
`default_nettype none
// ============================================================================
// Package  : kyber_pkg
// Brief    : Shared Kyber constants, coefficient type and encoder state type.
// Revision : 1.0 - initial release
// ============================================================================

package kyber_pkg;

   localparam int KYBER_N      = 256;
   localparam int KYBER_Q      = 3329;
   localparam int KYBER_Q_HALF = 1664;
   localparam int COEFF_W      = 16;
   localparam int POLY_W       = KYBER_N * COEFF_W;

   typedef logic signed [COEFF_W-1:0] coeff_t;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_RUN    = 2'd1,
      ST_FINISH = 2'd2
   } enc_state_t;

endpackage

`default_nettype wire

// File: rtl/poly_byte_encode_if.sv
`default_nettype none
// ============================================================================
// Interface : poly_byte_encode_if
// Brief     : Request and byte-stream signals of the polynomial byte encoder.
// Revision  : 1.0 - initial release
// ============================================================================

interface poly_byte_encode_if;
   import kyber_pkg::*;

   logic              start;
   logic [POLY_W-1:0] poly_in;
   logic [7:0]        out_byte;
   logic              out_valid;
   logic              out_ready;
   logic              busy;
   logic              done;

   modport master (
      output start, poly_in, out_ready,
      input  out_byte, out_valid, busy, done
   );

   modport slave (
      input  start, poly_in, out_ready,
      output out_byte, out_valid, busy, done
   );

endinterface

`default_nettype wire

// File: rtl/kyber_compress.sv
`default_nettype none
// ============================================================================
// Module   : kyber_compress
// Brief    : Normalises a signed coefficient into [0,q) and applies Compress_d.
// Revision : 1.0 - initial release
// ============================================================================

module kyber_compress
   import kyber_pkg::*;
#(
   parameter int D        = 10,
   parameter int COMPRESS = 1
) (
   input  wire coeff_t  coeff,
   output logic [D-1:0] y
);

   logic [11:0] w_norm;

   // The low 12 bits of c +/- q depend only on the low 12 bits of c.
   always_comb begin
      if (coeff < 0)
         w_norm = coeff[11:0] + 12'(KYBER_Q);
      else if (coeff >= coeff_t'(KYBER_Q))
         w_norm = coeff[11:0] - 12'(KYBER_Q);
      else
         w_norm = coeff[11:0];
   end

   generate
      if (COMPRESS != 0) begin : g_compress
         localparam int c_num_w = 12 + D;
         localparam int c_quo_w = D + 1;

         logic [c_num_w-1:0] w_num;
         logic [c_quo_w-1:0] w_quo;

         assign w_num = {w_norm, {D{1'b0}}} + c_num_w'(KYBER_Q_HALF);
         assign w_quo = c_quo_w'(w_num / c_num_w'(KYBER_Q));
         // Quotient peaks at exactly 2^D, which wraps to zero.
         assign y     = w_quo[D] ? '0 : w_quo[D-1:0];
      end else begin : g_raw
         assign y = w_norm[D-1:0];
      end
   endgenerate

endmodule

`default_nettype wire

// File: rtl/poly_byte_encode.sv
`default_nettype none
// ============================================================================
// Module   : poly_byte_encode
// Brief    : Compresses and ByteEncode_d-packs a polynomial into a byte stream.
// Revision : 1.0 - initial release
// ============================================================================

module poly_byte_encode
   import kyber_pkg::*;
#(
   parameter int D        = 10,
   parameter int COMPRESS = 1
) (
   input  wire               clk,
   input  wire               rst,
   poly_byte_encode_if.slave bus
);

   localparam int c_nbytes = 32 * D;

   enc_state_t        r_state, w_state_nxt;
   logic [POLY_W-1:0] r_poly, w_poly_nxt;
   logic [23:0]       r_acc, w_acc_nxt;
   logic [4:0]        r_fill, w_fill_nxt;
   logic [8:0]        r_idx, w_idx_nxt;
   logic [8:0]        r_bytes, w_bytes_nxt;
   logic [7:0]        r_out_byte, w_out_byte_nxt;
   logic              r_out_valid, w_out_valid_nxt;
   logic              w_hs, w_emit, w_absorb;
   coeff_t            w_coeff;
   logic [D-1:0]      w_y;

   // Coefficients are consumed from the bottom of a shifting copy of poly_in.
   assign w_coeff = coeff_t'(r_poly[COEFF_W-1:0]);

   kyber_compress #(
      .D        (D),
      .COMPRESS (COMPRESS)
   ) u_compress (
      .coeff (w_coeff),
      .y     (w_y)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state     <= ST_IDLE;
         r_acc       <= '0;
         r_fill      <= '0;
         r_idx       <= '0;
         r_bytes     <= '0;
         r_out_byte  <= '0;
         r_out_valid <= 1'b0;
      end else begin
         r_state     <= w_state_nxt;
         r_acc       <= w_acc_nxt;
         r_fill      <= w_fill_nxt;
         r_idx       <= w_idx_nxt;
         r_bytes     <= w_bytes_nxt;
         r_out_byte  <= w_out_byte_nxt;
         r_out_valid <= w_out_valid_nxt;
      end
   end

   always_ff @(posedge clk) begin
      r_poly <= w_poly_nxt;
   end

   always_comb begin
      w_state_nxt     = r_state;
      w_poly_nxt      = r_poly;
      w_acc_nxt       = r_acc;
      w_fill_nxt      = r_fill;
      w_idx_nxt       = r_idx;
      w_bytes_nxt     = r_bytes;
      w_out_byte_nxt  = r_out_byte;
      w_out_valid_nxt = r_out_valid;
      w_hs            = r_out_valid && bus.out_ready;
      w_emit          = 1'b0;
      w_absorb        = 1'b0;

      case (r_state)
         ST_IDLE: begin
            if (bus.start) begin
               w_poly_nxt  = bus.poly_in;
               w_acc_nxt   = '0;
               w_fill_nxt  = '0;
               w_idx_nxt   = '0;
               w_bytes_nxt = '0;
               w_state_nxt = ST_RUN;
            end
         end

         ST_RUN: begin
            if (w_hs) begin
               w_bytes_nxt     = r_bytes + 9'd1;
               w_out_valid_nxt = 1'b0;
            end
            w_emit = (r_fill >= 5'd8) && (!r_out_valid || bus.out_ready);
            if (w_emit) begin
               w_out_byte_nxt  = r_acc[7:0];
               w_out_valid_nxt = 1'b1;
               w_acc_nxt       = r_acc >> 8;
               w_fill_nxt      = r_fill - 5'd8;
            end
            // Absorbing against the post-emit fill keeps the fill at 19 or below.
            w_absorb = (w_fill_nxt < 5'd8) && (r_idx < 9'(KYBER_N));
            if (w_absorb) begin
               w_acc_nxt  = w_acc_nxt | (24'(w_y) << w_fill_nxt);
               w_fill_nxt = w_fill_nxt + 5'(D);
               w_idx_nxt  = r_idx + 9'd1;
               w_poly_nxt = r_poly >> COEFF_W;
            end
            if (w_hs && (r_bytes == 9'(c_nbytes - 1)))
               w_state_nxt = ST_FINISH;
         end

         ST_FINISH: begin
            w_state_nxt = ST_IDLE;
         end

         default: begin
            w_state_nxt = ST_IDLE;
         end
      endcase
   end

   assign bus.out_byte  = r_out_byte;
   assign bus.out_valid = r_out_valid;
   assign bus.busy      = (r_state == ST_RUN);
   assign bus.done      = (r_state == ST_FINISH);

endmodule

`default_nettype wire

// File: tb/tb_poly_byte_encode.sv
`default_nettype none
// ============================================================================
// Module   : tb_poly_byte_encode
// Brief    : Scoreboard bench for poly_byte_encode (D=4/10 compressed, D=12 raw).
// Revision : 1.0 - initial release
// ============================================================================

module tb_poly_byte_encode;
   import kyber_pkg::*;

   localparam int NDUT = 3;

   typedef struct packed {
      logic [1:0] sel;
      logic [7:0] b;
   } exp_t;

   logic clk;
   logic rst;

   logic              start_s [NDUT];
   logic [POLY_W-1:0] poly_s  [NDUT];
   logic              rdy_s   [NDUT];
   bit                rand_bp [NDUT];
   logic [7:0]        byte_o  [NDUT];
   logic              vld_o   [NDUT];
   logic              busy_o  [NDUT];
   logic              done_o  [NDUT];

   exp_t       exp_q[$];
   logic [7:0] cap[$];
   int         coef [KYBER_N];
   int         done_cnt [NDUT];
   int         hs_cnt   [NDUT];
   bit         stall    [NDUT];
   int         n_chk;
   int         n_fail;

   poly_byte_encode_if bus0 ();
   poly_byte_encode_if bus1 ();
   poly_byte_encode_if bus2 ();

   assign bus0.start = start_s[0];  assign bus0.poly_in = poly_s[0];  assign bus0.out_ready = rdy_s[0];
   assign bus1.start = start_s[1];  assign bus1.poly_in = poly_s[1];  assign bus1.out_ready = rdy_s[1];
   assign bus2.start = start_s[2];  assign bus2.poly_in = poly_s[2];  assign bus2.out_ready = rdy_s[2];
   assign byte_o[0] = bus0.out_byte;  assign vld_o[0] = bus0.out_valid;
   assign busy_o[0] = bus0.busy;      assign done_o[0] = bus0.done;
   assign byte_o[1] = bus1.out_byte;  assign vld_o[1] = bus1.out_valid;
   assign busy_o[1] = bus1.busy;      assign done_o[1] = bus1.done;
   assign byte_o[2] = bus2.out_byte;  assign vld_o[2] = bus2.out_valid;
   assign busy_o[2] = bus2.busy;      assign done_o[2] = bus2.done;

   poly_byte_encode #(.D(4),  .COMPRESS(1)) u_dut0 (.clk(clk), .rst(rst), .bus(bus0));
   poly_byte_encode #(.D(10), .COMPRESS(1)) u_dut1 (.clk(clk), .rst(rst), .bus(bus1));
   poly_byte_encode #(.D(12), .COMPRESS(0)) u_dut2 (.clk(clk), .rst(rst), .bus(bus2));

   coeff_t      cc;
   logic [0:0]  y1;
   logic [3:0]  y4;
   logic [9:0]  y10;
   logic [10:0] y11;

   kyber_compress #(.D(1),  .COMPRESS(1)) u_c1  (.coeff(cc), .y(y1));
   kyber_compress #(.D(4),  .COMPRESS(1)) u_c4  (.coeff(cc), .y(y4));
   kyber_compress #(.D(10), .COMPRESS(1)) u_c10 (.coeff(cc), .y(y10));
   kyber_compress #(.D(11), .COMPRESS(1)) u_c11 (.coeff(cc), .y(y11));

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic int dk(input int k);
      return (k == 0) ? 4 : ((k == 1) ? 10 : 12);
   endfunction

   // Reference: x = c mod q, then round(x * 2^d / q) mod 2^d, or x mod 2^d raw.
   function automatic int ref_y(input int c, input int d, input bit comp);
      int x;
      x = ((c % KYBER_Q) + KYBER_Q) % KYBER_Q;
      if (comp)
         return ((x * (1 << d) + KYBER_Q_HALF) / KYBER_Q) % (1 << d);
      return x % (1 << d);
   endfunction

   function automatic logic [POLY_W-1:0] pack_poly();
      logic [POLY_W-1:0] p;
      p = '0;
      for (int i = 0; i < KYBER_N; i++)
         p[i*COEFF_W +: COEFF_W] = 16'(coef[i]);
      return p;
   endfunction

   function automatic int cap_at(input int i);
      return (i < cap.size()) ? int'(cap[i]) : -1;
   endfunction

   task automatic chk(input string name, input int act, input int exp);
      n_chk++;
      if (act != exp) begin
         n_fail++;
         $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h) at %0t",
                  name, act, act, exp, exp, $time);
      end
   endtask

   task automatic rand_coefs();
      for (int i = 0; i < KYBER_N; i++)
         coef[i] = int'($urandom_range(0, 9985)) - 3328;
   endtask

   // Builds the whole bit string y0 | y1<<d | ... and slices it into bytes.
   task automatic push_model(input int k);
      logic [3071:0] bits;
      int            d;
      int            y;
      exp_t          e;
      d    = dk(k);
      bits = '0;
      for (int i = 0; i < KYBER_N; i++) begin
         y = ref_y(coef[i], d, k != 2);
         for (int b = 0; b < d; b++)
            bits[i*d + b] = ((y >> b) & 1) != 0;
      end
      for (int j = 0; j < 32 * d; j++) begin
         e.sel = 2'(k);
         e.b   = bits[j*8 +: 8];
         exp_q.push_back(e);
      end
   endtask

   task automatic do_stream(input int k, input bit bp);
      int d0;
      int cyc;
      push_model(k);
      cap.delete();
      rand_bp[k] = bp;
      d0 = done_cnt[k];
      @(posedge clk); #1;
      poly_s[k]  = pack_poly();
      start_s[k] = 1'b1;
      @(posedge clk); #1;
      start_s[k] = 1'b0;
      cyc = 1;
      while (done_cnt[k] == d0 && cyc < 4000) begin
         @(posedge clk); #1;
         cyc++;
      end
      chk($sformatf("done_pulse_dut%0d", k), done_cnt[k] - d0, 1);
      if (!bp)
         chk($sformatf("latency_bound_dut%0d", k), int'(cyc <= 32 * dk(k) + 261), 1);
      chk($sformatf("byte_count_dut%0d", k), cap.size(), 32 * dk(k));
      @(negedge clk);
      chk($sformatf("busy_after_dut%0d", k), int'(busy_o[k]), 0);
      chk($sformatf("done_after_dut%0d", k), int'(done_o[k]), 0);
      chk("queue_drained", exp_q.size(), 0);
      rand_bp[k] = 1'b0;
   endtask

   // Backpressure driver.
   initial begin
      for (int k = 0; k < NDUT; k++) rdy_s[k] = 1'b1;
      forever begin
         @(posedge clk); #1;
         for (int k = 0; k < NDUT; k++)
            rdy_s[k] = rand_bp[k] ? ($urandom_range(0, 2) != 0) : 1'b1;
      end
   end

   // Monitor: pops the scoreboard on every handshake.
   initial begin
      exp_t e;
      for (int k = 0; k < NDUT; k++) begin
         stall[k]    = 1'b0;
         done_cnt[k] = 0;
         hs_cnt[k]   = 0;
      end
      forever begin
         @(negedge clk);
         for (int k = 0; k < NDUT; k++) begin
            if (done_o[k] === 1'b1) done_cnt[k]++;
            if (!rst && stall[k])
               chk($sformatf("stall_valid_dut%0d", k), int'(vld_o[k]), 1);
            if (!rst && vld_o[k] === 1'b1) begin
               if (rdy_s[k]) begin
                  hs_cnt[k]++;
                  cap.push_back(byte_o[k]);
                  if (exp_q.size() != 0 && int'(exp_q[0].sel) == k) begin
                     e = exp_q.pop_front();
                     chk($sformatf("stream_byte_dut%0d", k), int'(byte_o[k]), int'(e.b));
                  end else begin
                     n_chk++;
                     n_fail++;
                     $display("FAIL unexpected_byte dut%0d: got 0x%0h, expected no byte at %0t",
                              k, byte_o[k], $time);
                  end
               end else if (exp_q.size() != 0 && int'(exp_q[0].sel) == k) begin
                  chk($sformatf("stall_byte_dut%0d", k), int'(byte_o[k]), int'(exp_q[0].b));
               end
            end
            stall[k] = !rst && (vld_o[k] === 1'b1) && !rdy_s[k];
         end
      end
   end

   initial begin
      #3000000;
      $display("FAIL watchdog: got timeout, expected test completion");
      $fatal(1, "watchdog expired");
   end

   initial begin
      int d0;
      int h0;
      int cyc;
      n_chk  = 0;
      n_fail = 0;
      rst    = 1'b1;
      cc     = '0;
      for (int k = 0; k < NDUT; k++) begin
         start_s[k] = 1'b0;
         poly_s[k]  = '0;
         rand_bp[k] = 1'b0;
      end
      @(posedge clk);
      @(negedge clk);
      for (int k = 0; k < NDUT; k++) begin
         chk($sformatf("rst_byte_dut%0d", k),  int'(byte_o[k]), 0);
         chk($sformatf("rst_valid_dut%0d", k), int'(vld_o[k]), 0);
         chk($sformatf("rst_busy_dut%0d", k),  int'(busy_o[k]), 0);
         chk($sformatf("rst_done_dut%0d", k),  int'(done_o[k]), 0);
      end
      // start together with rst must be ignored
      start_s[0] = 1'b1;
      @(posedge clk); #1;
      start_s[0] = 1'b0;
      chk("rst_beats_start", int'(busy_o[0]), 0);
      rst = 1'b0;

      for (int c = -3328; c <= 6657; c++) begin
         cc = coeff_t'(c);
         #1;
         chk("compress_d1",  int'(y1),  ref_y(c, 1, 1'b1));
         chk("compress_d4",  int'(y4),  ref_y(c, 4, 1'b1));
         chk("compress_d10", int'(y10), ref_y(c, 10, 1'b1));
         chk("compress_d11", int'(y11), ref_y(c, 11, 1'b1));
      end

      for (int i = 0; i < KYBER_N; i++) coef[i] = 0;
      do_stream(0, 1'b0);

      coef[0] = 1665; coef[1] = 832; coef[2] = -1; coef[3] = 0;
      do_stream(0, 1'b0);
      chk("d4_byte0", cap_at(0), 8'h48);
      chk("d4_byte1", cap_at(1), 8'h00);

      for (int i = 0; i < KYBER_N; i++) coef[i] = 0;
      coef[0] = 1664; coef[1] = 3328;
      do_stream(1, 1'b0);
      chk("d10_byte0", cap_at(0), 8'h00);
      chk("d10_byte1", cap_at(1), 8'h02);

      for (int i = 0; i < KYBER_N; i++) coef[i] = i;
      do_stream(2, 1'b0);
      chk("d12_byte0", cap_at(0), 8'h00);
      chk("d12_byte1", cap_at(1), 8'h10);
      chk("d12_byte2", cap_at(2), 8'h00);
      chk("d12_byte3", cap_at(3), 8'h02);
      do_stream(2, 1'b1);
      chk("d12_bp_byte1", cap_at(1), 8'h10);

      for (int r = 0; r < 2; r++)
         for (int k = 0; k < NDUT; k++) begin
            rand_coefs();
            do_stream(k, r == 1);
         end

      // Control: second start ignored, then abort by rst, then restart.
      rand_coefs();
      push_model(2);
      cap.delete();
      d0 = done_cnt[2];
      h0 = hs_cnt[2];
      @(posedge clk); #1;
      poly_s[2]  = pack_poly();
      start_s[2] = 1'b1;
      @(posedge clk); #1;
      start_s[2] = 1'b0;
      cyc = 0;
      while (hs_cnt[2] - h0 < 20 && cyc < 2000) begin @(posedge clk); #1; cyc++; end
      chk("ctl_reach_byte20", int'(hs_cnt[2] - h0 >= 20), 1);
      rand_coefs();
      poly_s[2]  = pack_poly();
      start_s[2] = 1'b1;
      @(posedge clk); #1;
      start_s[2] = 1'b0;
      chk("ctl_busy_kept", int'(busy_o[2]), 1);
      cyc = 0;
      while (hs_cnt[2] - h0 < 50 && cyc < 2000) begin @(posedge clk); #1; cyc++; end
      chk("ctl_reach_byte50", int'(hs_cnt[2] - h0 >= 50), 1);
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      exp_q.delete();
      @(negedge clk);
      chk("abort_valid", int'(vld_o[2]), 0);
      chk("abort_busy", int'(busy_o[2]), 0);
      repeat (5) @(posedge clk);
      #1;
      chk("abort_no_done", done_cnt[2] - d0, 0);
      rand_coefs();
      do_stream(2, 1'b0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule

`default_nettype wire

// File: doc/poly_byte_encode.md
Name: poly_byte_encode

Overview:
- Serialising encoder, the output-side counterpart of the noise sampler. The sampler turns byte strings into polynomials; this block turns a polynomial back into a byte string.
- Takes one 256-coefficient polynomial in the same 4096-bit packed layout the sampler produces: coeff i at poly_in[i*16 +: 16], signed 16-bit.
- Optionally applies Kyber Compress_d, packs the D-bit results LSB-first (ByteEncode_d), and streams bytes over a valid/ready interface.
- Used for ciphertext u (D=10), v (D=4) and public-key packing (D=12, no compression).

Parameters:
- D, 10, bits per encoded coefficient; legal range 1..12. Stream length is 32*D bytes.
- COMPRESS, 1, 1 = apply Compress_d before packing; 0 = pack the low D bits of the normalised coefficient.

Ports:
- clk  in  1  clock.
- rst  in  1  reset, synchronous, active-high. Single clock domain.
- start  in  1  one-cycle request to encode poly_in; ignored while busy.
- poly_in  in  4096  256 x 16-bit signed coefficients; sampled only on the start cycle.
- out_byte  out  8  current encoded byte.
- out_valid  out  1  out_byte is valid.
- out_ready  in  1  consumer accepts the byte when out_valid && out_ready at a clk edge.
- busy  out  1  high from start acceptance until done.
- done  out  1  one-cycle pulse after the final byte handshake.

Behaviour:
- Reset values (rst sampled high at a clk edge): out_byte=0, out_valid=0, busy=0, done=0, state IDLE, bit accumulator cleared, counters cleared.
- States: IDLE -> RUN -> FINISH -> IDLE.
  - IDLE: start=1 latches poly_in into an internal register, clears the coeff index, fill count and byte count, sets busy=1, and moves to RUN.
  - RUN: each cycle absorbs at most one coefficient and presents at most one byte.
  - FINISH: done=1 for exactly one cycle, busy=0 on the same cycle, then IDLE.
- Normalisation of each signed coefficient c:
  - if c<0, use c+3329;
  - else if c>=3329, use c-3329;
  - else use c.
  - Legal input range is [-3328, 6657]. Values outside it are undefined.
- Compression (COMPRESS=1): y = floor((x*2^D + 1664)/3329) mod 2^D for x in [0,3328]. This must be bit-exact for every x; no approximation error is allowed.
- No compression (COMPRESS=0): y = x[D-1:0].
- Packing:
  - 24-bit accumulator acc with fill count f.
  - Absorb y when f<8 and coefficients remain: acc |= y<<f, f += D.
  - When f>=8 and the output slot is free (or is being consumed this cycle): load out_byte=acc[7:0], out_valid=1, acc >>= 8, f -= 8.
  - Absorb and emit may occur on the same cycle. Invariant: f <= 19.
- Byte order: byte k of the encoding is bits 8k..8k+7 of the concatenation y0 | y1<<D | y2<<2D ... Byte 0 is emitted first.
- Handshake rules:
  - out_byte and out_valid hold stable while out_valid && !out_ready.
  - out_valid never drops without a handshake, except on rst.
- Latency:
  - first out_valid no earlier than 2 cycles after the start edge;
  - with out_ready held high, the full stream completes within 32*D + 256 + 4 cycles of start.
- Termination: after the 32*D-th handshake, go to FINISH. f must be 0 at that point, because 256*D is a multiple of 8.
- Boundary conditions:
  - start while busy: ignored, and the latched poly_in is unchanged.
  - start and rst together: rst wins.
  - rst mid-stream: next cycle out_valid=0 and busy=0; the partial stream is discarded with no done pulse.
  - out_ready high while out_valid=0: no effect.

Decomposition:
- kyber_pkg holds:
  - KYBER_N=256, KYBER_Q=3329, KYBER_Q_HALF=1664, COEFF_W=16, POLY_W=4096;
  - a coeff_t typedef (logic signed [15:0]).
- One sub-module: kyber_compress, combinational, parameters D and COMPRESS. It takes a 16-bit signed coefficient and returns the D-bit y (normalise plus compress). The same sub-module is reused later by the decoder side.

Test Plan:
- Exhaustive kyber_compress: x = -3328..6657 for D in {1,4,10,11} -> matches the reference formula for every x.
- D=4, COMPRESS=1, all coeffs 0 -> exactly 128 bytes of 0x00, then one done pulse, busy low afterwards.
- D=4, COMPRESS=1:
  - stimulus: coeff0=1665, coeff1=832, coeff2=-1 (0xFFFF), coeff3=0, rest 0;
  - expected: y0=8, y1=4, y2=16 mod 16=0;
  - response: byte0=0x48, byte1=0x00, and all 128 bytes match the model.
- D=10, COMPRESS=1:
  - stimulus: coeff0=1664, coeff1=3328, rest 0;
  - expected: y0=512, y1=0;
  - response: byte0=0x00, byte1=0x02, 320 bytes total.
- D=12, COMPRESS=0, coeff i = i:
  - byte0=0x00, byte1=0x10, byte2=0x00, byte3=0x02;
  - 384 bytes matching ByteEncode_12;
  - repeat with random out_ready backpressure -> identical byte sequence, out_byte stable during every stall.
- Control:
  - stimulus: D=12 stream; assert start again at byte 20; assert rst after byte 50; then restart with new poly_in;
  - required response: the second start is ignored; one cycle after rst out_valid=0, busy=0, done never pulsed; the restart produces the full new stream from byte 0.
